load_datapath_ctrl: RTL
=======================

Name: load_datapath_ctrl

Overview:
- Load-side counterpart of the store byte-enable/replication path.
- Accepts one load request from the execute/memory stage and issues a word-aligned read to data memory over a valid/ready request channel.
- Waits for the variable-latency read response, then extracts and sign- or zero-extends the byte, halfword or word.
- Returns the result to writeback on a valid/ready channel; misaligned, illegal and timed-out accesses are reported as faults.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before a timeout fault is raised; must be >= 2.
- TIMEOUT_EN, 1: 1 enables the timeout counter; 0 waits indefinitely.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  load request valid.
- req_ready  output  1  high only in IDLE.
- load_type  input  3  000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU; all other codes are illegal.
- addr  input  32  byte address (ALU result).
- rd  input  5  destination register tag.
- mem_req_valid  output  1  memory read request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_addr  output  32  {addr[31:2],2'b00}.
- mem_rsp_valid  input  1  read data valid.
- mem_rsp_data  input  32  read word.
- wb_valid  output  1  result valid.
- wb_ready  input  1  writeback accepts the result.
- wb_data  output  32  extended load result.
- wb_rd  output  5  latched rd.
- wb_fault  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal type.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. All outputs except req_ready are registered.
- Reset (asynchronous, any state):
  - state returns to IDLE;
  - mem_req_valid=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_fault=00, counter=0;
  - req_ready=1 once in IDLE.
  - A memory response arriving after reset is ignored.
- IDLE:
  - On req_valid && req_ready, latch load_type, addr, rd.
  - Illegal type → RESP with fault 11.
  - Else misaligned (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) → RESP with fault 01.
  - Faulting requests never assert mem_req_valid and set wb_data=0.
  - Illegal type takes priority over misalignment.
  - Otherwise → REQ.
- REQ:
  - mem_req_valid=1; mem_addr held stable until accepted.
  - On mem_req_ready → WAIT, counter cleared to 0; mem_req_valid drops the next cycle.
- WAIT:
  - mem_rsp_valid=1 → register the extracted data into wb_data, fault 00 → RESP.
  - Otherwise the counter increments.
  - With TIMEOUT_EN=1 and counter == TIMEOUT_CYCLES-1 and no response → RESP with fault 10 and wb_data=0.
  - A response on the same cycle as the timeout wins (fault 00).
- mem_rsp_valid in IDLE, REQ or RESP is ignored. A response can arrive no earlier than the cycle after request acceptance.
- RESP:
  - wb_valid=1; wb_data, wb_rd and wb_fault held stable while wb_ready=0.
  - On wb_ready → IDLE, wb_valid=0 the next cycle.
  - No new request is accepted in the same cycle.
- Extraction (off = latched addr[1:0]):
  - LB: byte mem_rsp_data[8*off+7:8*off], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: half = off[1] ? [31:16] : [15:0], sign-extended.
  - LHU: same half, zero-extended.
  - LW: full word.
- Latency: a good load with zero-wait memory gives wb_valid 3 cycles after request acceptance. Throughput is at most one load per 4 cycles.
- Single outstanding transaction only.

Test Plan:
- LB addr=0x1003, mem_rsp_data=0x80FF1234 → mem_addr=0x1000, wb_data=0xFFFFFF80, wb_fault=00.
- LHU addr=0x2002, rsp=0x80FF1234 → wb_data=0x000080FF. LH at the same address → 0xFFFF80FF. LBU addr=0x2000 → 0x00000034.
- LW addr=0x1002 → mem_req_valid never asserted, wb_valid with wb_fault=01, wb_data=0. load_type=011 → wb_fault=11.
- LW addr=0x3000, mem_req_ready low for 4 cycles then high, memory never responds → mem_addr stable throughout REQ. After 16 WAIT cycles, wb_fault=10. With TIMEOUT_EN=0 the block stays in WAIT for 100 cycles.
- LW, rsp=0xDEADBEEF, wb_ready low for 5 cycles → wb_valid, wb_data=0xDEADBEEF and wb_rd held stable. req_ready=0 until the cycle after the wb handshake.
- Assert rst_n=0 mid-WAIT, release, then a stale mem_rsp_valid pulse → outputs at reset values, no wb_valid. A following LB request completes normally.

Source files
------------

// File: rtl/load_datapath_ctrl.sv
// Load datapath controller: accepts one load, issues a word-aligned memory
// read, waits for the variable-latency response, then extracts and extends
// the addressed byte/halfword/word and hands it to writeback. Misaligned,
// illegal-type and timed-out loads complete with a fault code instead.
module load_datapath_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit TIMEOUT_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [4:0]  rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_fault
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [1:0] FAULT_OK        = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT   = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t         state_reg;
    logic [2:0]     type_reg;
    logic [1:0]     off_reg;
    logic [CW-1:0]  count_reg;

    logic           illegal;
    logic           misaligned;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    ext_data;

    // Only ready when no transaction is in flight.
    assign req_ready = (state_reg == IDLE);

    // Classify the incoming request; illegal type is checked before alignment.
    always_comb begin
        illegal    = 1'b1;
        misaligned = 1'b0;
        case (load_type)
            LT_LB, LT_LBU: illegal = 1'b0;
            LT_LH, LT_LHU: begin
                illegal    = 1'b0;
                misaligned = addr[0];
            end
            LT_LW: begin
                illegal    = 1'b0;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Pick the addressed lane from the returned word and extend it.
    always_comb begin
        byte_sel = 8'h00;
        case (off_reg)
            2'd0: byte_sel = mem_rsp_data[7:0];
            2'd1: byte_sel = mem_rsp_data[15:8];
            2'd2: byte_sel = mem_rsp_data[23:16];
            2'd3: byte_sel = mem_rsp_data[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = off_reg[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        ext_data = 32'h0000_0000;
        case (type_reg)
            LT_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  ext_data = {24'h000000, byte_sel};
            LT_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  ext_data = {16'h0000, half_sel};
            LT_LW:   ext_data = mem_rsp_data;
            default: ext_data = 32'h0000_0000;
        endcase
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            type_reg      <= 3'b000;
            off_reg       <= 2'b00;
            count_reg     <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= 32'h0000_0000;
            wb_valid      <= 1'b0;
            wb_data       <= 32'h0000_0000;
            wb_rd         <= 5'd0;
            wb_fault      <= FAULT_OK;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        type_reg <= load_type;
                        off_reg  <= addr[1:0];
                        wb_rd    <= rd;
                        if (illegal) begin
                            wb_fault  <= FAULT_ILLEGAL;
                            wb_data   <= 32'h0000_0000;
                            wb_valid  <= 1'b1;
                            state_reg <= RESP;
                        end else if (misaligned) begin
                            wb_fault  <= FAULT_MISALIGN;
                            wb_data   <= 32'h0000_0000;
                            wb_valid  <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            mem_addr      <= {addr[31:2], 2'b00};
                            mem_req_valid <= 1'b1;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        count_reg     <= '0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still wins.
                    if (mem_rsp_valid) begin
                        wb_data   <= ext_data;
                        wb_fault  <= FAULT_OK;
                        wb_valid  <= 1'b1;
                        state_reg <= RESP;
                    end else if (TIMEOUT_EN && (count_reg == COUNT_LAST)) begin
                        wb_data   <= 32'h0000_0000;
                        wb_fault  <= FAULT_TIMEOUT;
                        wb_valid  <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        wb_valid  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
